// File: rtl/arb_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter and its pick logic.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int PTR_W = 3;

  typedef logic [N_REQ-1:0] onehot_t;
  typedef logic [PTR_W-1:0] idx_t;

  function automatic idx_t onehot2idx(input onehot_t oh);
    idx_t r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) r = idx_t'(i);
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational rotating first-set finder: first candidate at ptr+1, ptr+2, ... modulo 8.
module rr_pick
  import arb_pkg::*;
(
  input  logic [7:0] candidates,
  input  logic [2:0] ptr,
  output logic [7:0] onehot,
  output logic       any
);

  idx_t k;
  logic found;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    k      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // The 3-bit add wraps 7 -> 0 naturally.
      k = ptr + idx_t'(i + 1);
      if (!found && candidates[k]) begin
        onehot[k] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |candidates;

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Eight-requester round-robin arbiter with pending capture and a registered one-hot
// grant held under valid/ready backpressure.
module rr_onehot_arbiter
  import arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] grant_o,
  output logic [7:0] pending_o,
  output logic       merge_o
);

  onehot_t pending_p0;
  idx_t    ptr_p0;
  onehot_t grant_p1;
  logic    vld_p1;
  logic    merge_p1;

  logic    accept;
  onehot_t accepted;
  onehot_t cand;
  idx_t    search_ptr;
  onehot_t win;
  logic    win_any;

  assign accept   = vld_p1 & ready_i;
  assign accepted = accept ? grant_p1 : '0;
  assign cand     = pending_p0 & ~accepted;
  // Search resumes just past the bit being accepted so the same-cycle pick is already fair.
  assign search_ptr = accept ? onehot2idx(grant_p1) : ptr_p0;

  rr_pick u_pick (
    .candidates (cand),
    .ptr        (search_ptr),
    .onehot     (win),
    .any        (win_any)
  );

  // Stage p0: pending capture and pointer; stage p1: held grant and merge pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_p0 <= '0;
      ptr_p0     <= idx_t'(N_REQ - 1);
      grant_p1   <= '0;
      vld_p1     <= 1'b0;
      merge_p1   <= 1'b0;
    end else begin
      pending_p0 <= cand | req_i;
      merge_p1   <= |(req_i & cand);
      if (accept) ptr_p0 <= onehot2idx(grant_p1);
      if (!vld_p1 || ready_i) begin
        grant_p1 <= win;
        vld_p1   <= win_any;
      end
    end
  end

  assign valid_o   = vld_p1;
  assign grant_o   = grant_p1;
  assign pending_o = pending_p0;
  assign merge_o   = merge_p1;

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) vld_p1 |-> $onehot(grant_p1));
  a_subset: assert property (@(posedge clk) disable iff (!rst_n) (grant_p1 & ~pending_p0) == '0);

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Eight-requester round-robin arbiter that sits directly upstream of the 8-to-3 encoder.
- Captures request lines into a pending register and selects one pending requester fairly.
- Presents the selection as a registered one-hot grant (exactly one bit set) under a valid/ready handshake.
- The encoder consumes grant_o combinationally; the attached consumer drives ready_i.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 to match the encoder input width.
- PTR_W, 3, width of the round-robin pointer, equal to log2(N_REQ).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_i  input  8  request lines; any cycle with bit k high sets pending[k].
- ready_i  input  1  consumer accepts the current grant this cycle.
- valid_o  output  1  grant_o holds a valid one-hot grant.
- grant_o  output  8  one-hot grant; all zero when valid_o is low.
- pending_o  output  8  current pending register, for debug/status.
- merge_o  output  1  one-cycle pulse: a req_i bit arrived while that bit was already pending or currently granted (request merged, not queued).

Behaviour:
- Reset: when rst_n=0 at a clk edge, clear pending, grant_o and valid_o; set merge_o=0 and ptr=7, so the first search starts at bit 0.
- Pending update each edge: pending_next = (pending & ~accepted_bit) | req_i.
  - accepted_bit = grant_o when valid_o & ready_i, otherwise 0.
  - If req_i[k] is set in the same cycle bit k is accepted, pending[k] stays set; set wins over clear.
- Arbitration is registered, with no combinational path from req_i or ready_i to grant_o.
  - Candidate set C = pending & ~accepted_bit, using the registered pending only. req_i arriving this cycle is not eligible until the next cycle.
  - Winner = first set bit of C searching ptr+1, ptr+2, ... modulo 8, wrapping 7 to 0.
- Output register, HOLD semantics:
  - valid_o=1 and ready_i=0: grant_o and valid_o hold stable, and pending keeps accumulating.
  - valid_o=0, or valid_o=1 and ready_i=1: if C is non-zero, load grant_o with the one-hot winner and set valid_o=1. Otherwise clear grant_o and valid_o.
  - On acceptance, ptr loads the index of the accepted bit; ptr changes only on acceptance.
- Latency:
  - req_i high at edge t sets pending at t+1.
  - With the output idle, grant_o and valid_o are asserted after edge t+2.
  - Back-to-back accepts run at full rate: one grant per cycle while ready_i=1 and further requests are pending.
- A currently granted bit that is still held stays set in pending until accepted, so it is never re-granted while held.
- merge_o = OR over k of (req_i[k] & pending[k] & ~accepted_bit[k]). It is registered, so it pulses one cycle later.
- Invariants (both are assertions):
  - valid_o implies exactly one bit of grant_o is set.
  - grant_o is a subset of pending.
- Reset mid-operation: a held grant is dropped without acceptance. No state survives reset.

Decomposition:
- Shared package arb_pkg holds:
  - N_REQ=8 and PTR_W=3 constants.
  - An onehot_t typedef (logic [7:0]).
  - An idx_t typedef (logic [2:0]).
- One natural sub-module, rr_pick: a purely combinational rotating first-set finder.
  - Inputs: candidates[7:0], ptr[2:0].
  - Outputs: onehot[7:0], any.
  - Implementation: double-width mask or rotate-priority-rotate-back.
- Top level keeps the pending register, the pointer, the output register and the merge logic.

Test Plan:
- Reset then req_i=8'h01 for one cycle, ready_i=1: grant_o=8'h01 with valid_o high two edges later for exactly one cycle; pending_o returns to 0.
- All requests: req_i=8'hFF for one cycle, ready_i=1 continuously: grant_o sequence 01,02,04,08,10,20,40,80 on consecutive cycles, then valid_o=0.
- Fairness: req_i held at 8'h81, ready_i=1: grants alternate 01,80,01,80; the 8'h80 requester never starves.
- Backpressure: grant_o=8'h04 with ready_i=0 for 5 cycles while req_i=8'h10 pulses: grant_o stays 04 and pending_o=8'h14. Raising ready_i gives 04 then 10.
- Merge/set-wins: pulse req_i[3] while bit 3 is pending → merge_o pulses once. Assert req_i[3] in the accept cycle of grant 08 → pending_o[3] stays 1 and 08 is granted again next round.
- Reset mid-hold: valid_o=1, grant_o=8'h20, ready_i=0, rst_n=0 for one edge → valid_o=0, grant_o=0, pending_o=0; the next grant after reset searches from bit 0.
